// File: rtl/pwm_bank_pkg.sv
// Shared constants for the SPI-configured PWM bank.
// Frame layout, register addresses and channel-mask helper.
package pwm_bank_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int MAX_CH     = 16;

    localparam logic [ADDR_W-1:0] A_OUT_LO    = 7'h00;
    localparam logic [ADDR_W-1:0] A_OUT_HI    = 7'h01;
    localparam logic [ADDR_W-1:0] A_PWM_LO    = 7'h02;
    localparam logic [ADDR_W-1:0] A_PWM_HI    = 7'h03;
    localparam logic [ADDR_W-1:0] A_PRESCALE  = 7'h04;
    localparam logic [ADDR_W-1:0] A_DUTY_BASE = 7'h10;

    function automatic logic [MAX_CH-1:0] ch_mask(input int n);
        logic [MAX_CH-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/pwm_bank_spi_rw_spi.sv
// SPI mode-0 register interface: pin sync, edge detect, frame
// shifter, write strobe generation and CIPO readback shifter.
module spi_regif_rw
    import pwm_bank_pkg::*;
#(
    parameter int SYNC_FF = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              copi,
    input  logic              ncs,
    input  logic [7:0]        rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              cipo,
    output logic              cipo_oe
);

    localparam logic [4:0] LAST = 5'(FRAME_BITS);

    logic [SYNC_FF-1:0]    sclk_sync, copi_sync, ncs_sync;
    logic                  sclk_s, copi_s, ncs_s;
    logic                  sclk_d, ncs_d;
    logic                  sclk_rise, sclk_fall, ncs_rise;
    logic [FRAME_BITS-1:0] shreg;
    logic [4:0]            bit_cnt;
    logic [7:0]            cipo_sh;

    assign sclk_s    = sclk_sync[SYNC_FF-1];
    assign copi_s    = copi_sync[SYNC_FF-1];
    assign ncs_s     = ncs_sync[SYNC_FF-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ncs_rise  = ncs_s & ~ncs_d;

    // Address is complete on the 8th rising edge, before it lands in shreg.
    assign rd_addr = {shreg[5:0], copi_s};
    assign cipo    = cipo_sh[7];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '0;
            sclk_d    <= 1'b0;
            ncs_d     <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            cipo_sh   <= '0;
            cipo_oe   <= 1'b0;
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_FF-2:0], sclk};
            copi_sync <= {copi_sync[SYNC_FF-2:0], copi};
            ncs_sync  <= {ncs_sync[SYNC_FF-2:0], ncs};
            sclk_d    <= sclk_s;
            ncs_d     <= ncs_s;
            wr_stb    <= 1'b0;
            if (ncs_rise) begin
                if (bit_cnt == LAST && shreg[FRAME_BITS-1]) begin
                    wr_stb  <= 1'b1;
                    wr_addr <= shreg[14:8];
                    wr_data <= shreg[7:0];
                end
                bit_cnt <= '0;
                cipo_sh <= '0;
                cipo_oe <= 1'b0;
            end else if (ncs_s) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                shreg <= {shreg[FRAME_BITS-2:0], copi_s};
                if (bit_cnt != LAST + 5'd1) bit_cnt <= bit_cnt + 5'd1;
                if (bit_cnt == 5'd7 && !shreg[6]) begin
                    cipo_sh <= rd_data;
                    cipo_oe <= 1'b1;
                end
            end else if (sclk_fall && cipo_oe && bit_cnt > 5'd8) begin
                // data[7] stays up across the 8th fall for the 9th rise
                cipo_sh <= {cipo_sh[6:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/pwm_bank_spi_rw.sv
// PWM bank with SPI read/write register file, prescaler and
// per-channel PWM/static output stage.
module pwm_bank_spi_rw
    import pwm_bank_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int SYNC_FF = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              sclk,
    input  logic              copi,
    input  logic              ncs,
    output logic              cipo,
    output logic              cipo_oe,
    output logic [NUM_CH-1:0] ch_out
);

    localparam logic [MAX_CH-1:0] MASK = ch_mask(NUM_CH);

    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [7:0]        rd_data, wr_data;
    logic              wr_stb;
    logic [MAX_CH-1:0] out_en, pwm_en;
    logic [7:0]        prescale, pre_cnt, pwm_cnt;
    logic [7:0]        duty [NUM_CH];
    logic              tick;
    logic [NUM_CH-1:0] ch_next;

    spi_regif_rw #(.SYNC_FF(SYNC_FF)) u_spi (
        .clk     (clk),
        .rst     (rst),
        .sclk    (sclk),
        .copi    (copi),
        .ncs     (ncs),
        .rd_data (rd_data),
        .rd_addr (rd_addr),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .cipo    (cipo),
        .cipo_oe (cipo_oe)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_en   <= '0;
            pwm_en   <= '0;
            prescale <= '0;
            for (int c = 0; c < NUM_CH; c++) duty[c] <= '0;
        end else if (wr_stb) begin
            case (wr_addr)
                A_OUT_LO:   out_en[7:0]  <= wr_data & MASK[7:0];
                A_OUT_HI:   out_en[15:8] <= wr_data & MASK[15:8];
                A_PWM_LO:   pwm_en[7:0]  <= wr_data & MASK[7:0];
                A_PWM_HI:   pwm_en[15:8] <= wr_data & MASK[15:8];
                A_PRESCALE: prescale     <= wr_data;
                default: ;
            endcase
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_addr == A_DUTY_BASE + 7'(c)) duty[c] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            A_OUT_LO:   rd_data = out_en[7:0];
            A_OUT_HI:   rd_data = out_en[15:8];
            A_PWM_LO:   rd_data = pwm_en[7:0];
            A_PWM_HI:   rd_data = pwm_en[15:8];
            A_PRESCALE: rd_data = prescale;
            default: ;
        endcase
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_addr == A_DUTY_BASE + 7'(c)) rd_data = duty[c];
        end
    end

    assign tick = ena && (pre_cnt == prescale);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            if (wr_stb && wr_addr == A_PRESCALE) pre_cnt <= '0;
            else if (ena) pre_cnt <= tick ? 8'd0 : pre_cnt + 8'd1;
            if (tick) pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic pwm_c;
        assign pwm_c      = (duty[c] == 8'hFF) | (pwm_cnt < duty[c]);
        assign ch_next[c] = out_en[c] & (pwm_en[c] ? pwm_c : 1'b1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ch_out <= '0;
        else     ch_out <= ch_next;
    end

endmodule
